// File: rtl/pipe_fifo.sv
// pipe_fifo: DEPTH-entry circular-buffer FIFO with valid/allow handshakes.
// Optional zero-latency pass-through when empty is enabled by defining
// PIPE_FIFO_BYPASS_EN. The default build (macro undefined) gives a minimum
// in-to-out latency of one cycle, and valid_out never depends on valid_in.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module pipe_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     valid_in,
  output logic                     allow_in,
  input  logic [WIDTH-1:0]         in,
  output logic                     valid_out,
  input  logic                     allow_out,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Storage is deliberately left unreset; only pointers and count are cleared.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;

  logic stored_valid;  // at least one word sits in the buffer
  logic push_store;    // word written into the buffer this cycle
  logic pop_store;     // buffered word consumed this cycle

  assign stored_valid = (count_reg != '0);
  assign count        = count_reg;

  // Acceptance depends only on occupancy and flush, never on allow_out/valid_in.
  assign allow_in = (count_reg != FULL_COUNT) && !flush;

`ifdef PIPE_FIFO_BYPASS_EN
  logic bypass_xfer;  // word goes straight from in to out, never stored

  // When empty, present the incoming word directly; otherwise the buffer head.
  always_comb begin
    valid_out   = 1'b0;
    out         = mem[rd_ptr_reg];
    bypass_xfer = 1'b0;
    if (stored_valid) begin
      valid_out = !flush;
    end else begin
      valid_out   = valid_in && !flush;
      out         = in;
      bypass_xfer = valid_in && !flush && allow_out;
    end
    push_store = valid_in && allow_in && !bypass_xfer;
    pop_store  = stored_valid && valid_out && allow_out;
  end
`else
  // Output is always the buffer head; flush masks valid_out in its own cycle.
  always_comb begin
    valid_out  = stored_valid && !flush;
    out        = mem[rd_ptr_reg];
    push_store = valid_in && allow_in;
    pop_store  = valid_out && allow_out;
  end
`endif

  // Next-state for pointers and occupancy; flush discards any push or pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_store) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop_store)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push_store, pop_store})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State register; reset overrides flush, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Buffer write at the write pointer; a push is ignored under reset.
  always_ff @(posedge clk) begin
    if (push_store && !reset) begin
      mem[wr_ptr_reg] <= in;
    end
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// Testbench for pipe_fifo: directed scenarios plus randomized traffic checked
// against a queue-based reference model and an output scoreboard.
module tb_pipe_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic                    valid_in;
  logic                    allow_in;
  logic [WIDTH-1:0]        din;
  logic                    valid_out;
  logic                    allow_out;
  logic [WIDTH-1:0]        dout;
  logic [$clog2(DEPTH):0]  count;

  pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .allow_in(allow_in), .in(din),
    .valid_out(valid_out), .allow_out(allow_out), .out(dout),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic checking = 1'b0;
  logic acc = 1'b0;              // model says the last offered word was accepted
  logic [WIDTH-1:0] exp_q[$];    // words expected to leave, in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: inputs are stable mid-cycle, so compare the
  // combinational outputs here, then commit what the coming edge will do.
  always @(negedge clk) begin
    int  sz;
    logic e_allow, e_valid, byp, popd, pushd;
    if (checking) begin
      sz      = exp_q.size();
      e_allow = (sz != DEPTH) && !flush;
      e_valid = (sz != 0) && !flush;
      byp     = 1'b0;
`ifdef PIPE_FIFO_BYPASS_EN
      if (sz == 0 && valid_in && !flush) begin
        e_valid = 1'b1;
        byp     = 1'b1;
      end
`endif
      chk("count", 64'(count), 64'(sz));
      chk("allow_in", 64'(allow_in), 64'(e_allow));
      chk("valid_out", 64'(valid_out), 64'(e_valid));
      if (e_valid) chk("out", 64'(dout), byp ? 64'(din) : 64'(exp_q[0]));
      popd  = e_valid && allow_out && !reset;
      pushd = valid_in && e_allow && !reset;
      if (popd) $display("xfer out=%08h count=%0d", dout, count);
      acc = pushd;
      if (reset || flush) begin
        exp_q.delete();
        acc = 1'b0;
      end else if (!(byp && allow_out)) begin
        if (popd)  void'(exp_q.pop_front());
        if (pushd) exp_q.push_back(din);
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic cyc(input logic vi, input logic [WIDTH-1:0] d, input logic ao,
                     input logic fl, input logic rs);
    valid_in  = vi;
    din       = d;
    allow_out = ao;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + WIDTH'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int k, guard;
    logic tog;
    valid_in = 0; din = '0; allow_out = 0; flush = 0; reset = 1;
    @(posedge clk); #1;
    checking = 1'b1;
    cyc(0, '0, 0, 0, 1);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_allow_in", 64'(allow_in), 64'd1);

    // Fill to full, then offer a fifth word that must be refused.
    fill(32'hA0, 4);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_allow_in", 64'(allow_in), 64'd0);
    cyc(1, 32'hA4, 0, 0, 0);
    chk("full_hold_count", 64'(count), 64'd4);
    drain(4);
    chk("drain_valid_out", 64'(valid_out), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Full: pop one, then push while popping.
    fill(32'hC0, 4);
    cyc(0, '0, 1, 0, 0);
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_allow_in", 64'(allow_in), 64'd1);
    cyc(1, 32'hB0, 1, 0, 0);
    chk("simul_count", 64'(count), 64'd3);
    drain(4);

    // Single entry, simultaneous push and pop.
    fill(32'hD0, 1);
    cyc(1, 32'hD1, 1, 0, 0);
    chk("one_simul_count", 64'(count), 64'd1);
    chk("one_simul_out", 64'(dout), 64'hD1);
    drain(2);

    // Wrap: 10 words with allow_out toggling every cycle.
    k = 0; guard = 0; tog = 1'b0;
    while (k < 10 && guard < 200) begin
      cyc(1, WIDTH'(k), tog, 0, 0);
      if (acc) k++;
      tog = !tog;
      guard++;
    end
    chk("wrap_budget", 64'(k), 64'd10);
    drain(6);
    chk("wrap_empty", 64'(count), 64'd0);

    // Flush with a word offered, then the same with reset.
    fill(32'hE0, 3);
    cyc(1, 32'hEE, 0, 1, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid_out", 64'(valid_out), 64'd0);
    fill(32'hF0, 4);
    cyc(1, 32'hFF, 0, 0, 1);
    chk("reset_full_count", 64'(count), 64'd0);
    chk("reset_full_valid_out", 64'(valid_out), 64'd0);
    chk("reset_full_allow_in", 64'(allow_in), 64'd1);

    // Empty FIFO, word offered with downstream ready.
    cyc(1, 32'h55, 1, 0, 0);
`ifdef PIPE_FIFO_BYPASS_EN
    chk("bypass_count", 64'(count), 64'd0);
`else
    chk("latency_valid_out", 64'(valid_out), 64'd1);
    chk("latency_out", 64'(dout), 64'h55);
`endif
    drain(2);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 1));
    end
    drain(DEPTH + 2);
    chk("final_count", 64'(count), 64'd0);
    chk("final_model_empty", 64'(exp_q.size()), 64'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
